// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer_pkg
// Purpose  : Shared encodings for the iterative multiply/divide sequencer.
//            - MD_MULT / MD_MULTU / MD_DIV / MD_DIVU : 2-bit op codes
//            - MD_IDLE / MD_RUN / MD_FIXUP / MD_DONE : 2-bit state codes
//            - MD_ITER : number of shift-add / restoring-divide iterations
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] MD_IDLE  = 2'b00;
    localparam logic [1:0] MD_RUN   = 2'b01;
    localparam logic [1:0] MD_FIXUP = 2'b10;
    localparam logic [1:0] MD_DONE  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = MD_IDLE,
        ST_RUN   = MD_RUN,
        ST_FIXUP = MD_FIXUP,
        ST_DONE  = MD_DONE
    } md_state_e;

endpackage : muldiv_sequencer_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational iteration of the multiply/divide datapath.
//   Multiply mode: accumulator = {prod_hi, prod_lo}; if prod_lo LSB is set,
//     add the multiplicand into prod_hi (carry kept), then shift the whole
//     (2*WIDTH+1)-bit value right by one.
//   Divide mode: accumulator = {rem, quot}; shift left by one, trial-subtract
//     the divisor from the (WIDTH+1)-bit shifted remainder, keep the
//     difference and set the quotient LSB when it does not go negative.
// Ports:
//   acc_i      [2*WIDTH-1:0]  current accumulator
//   operand_i  [WIDTH-1:0]    multiplicand or divisor
//   div_mode_i                1 = divide iteration, 0 = multiply iteration
//   acc_o      [2*WIDTH-1:0]  next accumulator
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               div_mode_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH:0]   w_mul_acc;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_diff;

    always_comb begin
        // Multiply: the upper half never carries a bit above 2*WIDTH-1 between
        // iterations, so the add is widened by one bit only here.
        w_mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i};
        w_mul_acc = acc_i[0] ? {w_mul_sum, acc_i[WIDTH-1:0]} : {1'b0, acc_i};

        // Divide: the shifted remainder is WIDTH+1 bits wide; when it is not
        // below the divisor the true difference fits in WIDTH bits, so the
        // truncated subtraction is exact.
        w_rem_sh   = acc_i[2*WIDTH-1:WIDTH-1];
        w_rem_ge   = (w_rem_sh >= {1'b0, operand_i});
        w_rem_diff = w_rem_sh[WIDTH-1:0] - operand_i;

        if (div_mode_i) begin
            if (w_rem_ge) begin
                acc_o = {w_rem_diff, acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {w_rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = w_mul_acc[2*WIDTH:1];
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative MULT/MULTU/DIV/DIVU controller producing the {hi,lo}
//            result for the LO/HI register pair. WIDTH iterations of the
//            muldiv_step datapath followed by one sign-fixup cycle; fixed
//            start-to-done latency of WIDTH+2 cycles.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   start               request, sampled only in IDLE or DONE
//   op [1:0]            00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   flush               abort an in-flight operation (wins over start)
//   busy                RUN or FIXUP
//   done                one-cycle pulse in DONE, result valid
//   loHi_out            {hi, lo}, held until the next completion
//   div_by_zero         set with done for a divide by zero, cleared on accept
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] loHi_out,
    output logic               div_by_zero
);

    localparam int              CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    md_state_e          r_state_q;
    logic               r_is_div_q;
    logic               r_is_signed_q;
    logic               r_res_neg_q;
    logic               r_rem_neg_q;
    logic               r_dbz_pend_q;
    logic [WIDTH-1:0]   r_operand_q;
    logic [2*WIDTH-1:0] r_acc_q;
    logic [CNT_W-1:0]   r_cnt_q;
    logic [2*WIDTH-1:0] r_lohi_q;
    logic               r_dbz_q;

    logic               w_accept;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc_d;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [2*WIDTH-1:0] w_result;

    // ------------------------------------------------------------------
    // Accept-time operand conditioning
    // ------------------------------------------------------------------
    always_comb begin
        w_accept    = ((r_state_q == ST_IDLE) || (r_state_q == ST_DONE)) && start && !flush;
        w_is_div    = (op == MD_DIV) || (op == MD_DIVU);
        w_is_signed = !((op == MD_MULTU) || (op == MD_DIVU));
        w_a_neg     = w_is_signed && src_a[WIDTH-1];
        w_b_neg     = w_is_signed && src_b[WIDTH-1];
        // The most negative value maps onto itself, which is the correct
        // unsigned magnitude 2^(WIDTH-1).
        w_a_mag     = w_a_neg ? -src_a : src_a;
        w_b_mag     = w_b_neg ? -src_b : src_b;
    end

    muldiv_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .acc_i      (r_acc_q),
        .operand_i  (r_operand_q),
        .div_mode_i (r_is_div_q),
        .acc_o      (w_acc_d)
    );

    // ------------------------------------------------------------------
    // Sign fixup. A divide by zero leaves quot = all ones and rem = |a|;
    // only the remainder is re-signed so hi returns the original dividend.
    // ------------------------------------------------------------------
    always_comb begin
        w_prod_fix = (r_is_signed_q && r_res_neg_q) ? -r_acc_q : r_acc_q;
        w_quot_fix = (r_is_signed_q && r_res_neg_q && !r_dbz_pend_q)
                   ? -r_acc_q[WIDTH-1:0] : r_acc_q[WIDTH-1:0];
        w_rem_fix  = (r_is_signed_q && r_rem_neg_q)
                   ? -r_acc_q[2*WIDTH-1:WIDTH] : r_acc_q[2*WIDTH-1:WIDTH];
        w_result   = r_is_div_q ? {w_rem_fix, w_quot_fix} : w_prod_fix;
    end

    // ------------------------------------------------------------------
    // Sequencer FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state_q     <= ST_IDLE;
            r_is_div_q    <= 1'b0;
            r_is_signed_q <= 1'b0;
            r_res_neg_q   <= 1'b0;
            r_rem_neg_q   <= 1'b0;
            r_dbz_pend_q  <= 1'b0;
            r_operand_q   <= '0;
            r_acc_q       <= '0;
            r_cnt_q       <= '0;
            r_lohi_q      <= '0;
            r_dbz_q       <= 1'b0;
        end else begin
            case (r_state_q)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state_q     <= ST_RUN;
                        r_is_div_q    <= w_is_div;
                        r_is_signed_q <= w_is_signed;
                        r_res_neg_q   <= w_a_neg ^ w_b_neg;
                        r_rem_neg_q   <= w_a_neg;
                        r_dbz_pend_q  <= w_is_div && (src_b == '0);
                        // Multiply: multiplier in the low half, multiplicand
                        // as operand. Divide: dividend low, divisor operand.
                        r_operand_q   <= w_is_div ? w_b_mag : w_a_mag;
                        r_acc_q       <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        r_cnt_q       <= '0;
                        r_dbz_q       <= 1'b0;
                    end else begin
                        r_state_q     <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_state_q <= ST_IDLE;
                    end else begin
                        r_acc_q <= w_acc_d;
                        r_cnt_q <= r_cnt_q + 1'b1;
                        if (r_cnt_q == c_last) begin
                            r_state_q <= ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    if (flush) begin
                        r_state_q <= ST_IDLE;
                    end else begin
                        r_lohi_q  <= w_result;
                        r_dbz_q   <= r_dbz_pend_q;
                        r_state_q <= ST_DONE;
                    end
                end
                default: begin
                    r_state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state_q == ST_RUN) || (r_state_q == ST_FIXUP);
    assign done        = (r_state_q == ST_DONE);
    assign loHi_out    = r_lohi_q;
    assign div_by_zero = r_dbz_q;

endmodule : muldiv_sequencer
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer. Directed operations
//            push their expected {hi,lo}, flag and completion cycle into a
//            scoreboard queue; an independent monitor pops and compares
//            whenever done is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [63:0] loHi_out;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] lohi;
        logic        dbz;
        int          due;
        int          id;
    } exp_t;

    exp_t sb[$];

    muldiv_sequencer #(
        .WIDTH       (32)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .loHi_out    (loHi_out),
        .div_by_zero (div_by_zero)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST_N && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
            end else begin
                e = sb.pop_front();
                check($sformatf("op%0d_lohi", e.id), loHi_out, e.lohi);
                check($sformatf("op%0d_dbz", e.id), {63'b0, div_by_zero}, {63'b0, e.dbz});
                check($sformatf("op%0d_done_cycle", e.id), 64'(cyc), 64'(e.due));
            end
        end
    end

    // Issue one op; done is due 33 edges after the accepting edge (cycle 34).
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_lohi, input logic exp_dbz,
                          input int id, input bit push);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        if (push) sb.push_back('{lohi: exp_lohi, dbz: exp_dbz, due: cyc + 33, id: id});
    endtask

    task automatic wait_done(input int id);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            seen = done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL op%0d_timeout: got no done expected done within 40 cycles", id);
        end
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] lohi;
        logic        dbz;
    } vec_t;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        vec_t vecs[$];

        // ---------------- reset state ----------------
        repeat (3) @(negedge CLK);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_lohi", loHi_out, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // ---------------- MULT 7 * -3 with busy/done timeline ----------------
        launch(MD_MULT, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            @(negedge CLK);
            check($sformatf("busy_done_cycle%0d", k), {62'b0, busy, done}, 64'b10);
        end
        @(negedge CLK);
        check("busy_done_cycle34", {62'b0, busy, done}, 64'b01);

        // ---------------- directed result vectors ----------------
        vecs.push_back('{MD_DIVU,  32'd100,          32'd7,          {32'd2,          32'd14},          1'b0});
        vecs.push_back('{MD_DIV,   32'hFFFF_FFF9,    32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD},   1'b0});
        vecs.push_back('{MD_DIV,   32'h8000_0000,    32'hFFFF_FFFF,  {32'd0,          32'h8000_0000},   1'b0});
        vecs.push_back('{MD_MULT,  32'h8000_0000,    32'h8000_0000,  64'h4000_0000_0000_0000,            1'b0});
        vecs.push_back('{MD_MULTU, 32'hFFFF_FFFF,    32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001,            1'b0});
        vecs.push_back('{MD_DIV,   32'hFFFF_FFF9,    32'd0,          {32'hFFFF_FFF9,  32'hFFFF_FFFF},   1'b1});
        vecs.push_back('{MD_DIV,   32'd5,            32'd0,          {32'd5,          32'hFFFF_FFFF},   1'b1});
        foreach (vecs[i]) begin
            launch(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].lohi, vecs[i].dbz, 10 + i, 1'b1);
            wait_done(10 + i);
        end

        // ---------------- MULTU 3*4 clears the divide-by-zero flag ----------------
        launch(MD_MULTU, 32'd3, 32'd4, 64'd12, 1'b0, 20, 1'b1);
        @(negedge CLK);
        check("dbz_cleared_on_accept", {63'b0, div_by_zero}, 64'd0);
        wait_done(20);

        // ---------------- flush at cycle 10 ----------------
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, 21, 1'b0);
        repeat (9) @(posedge CLK);
        #1 flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        @(negedge CLK);
        check("flush_busy_c11", {63'b0, busy}, 64'd0);
        check("flush_done_c11", {63'b0, done}, 64'd0);
        check("flush_lohi_kept", loHi_out, 64'd12);
        repeat (40) @(negedge CLK);
        check("flush_busy_later", {63'b0, busy}, 64'd0);

        // ---------------- start held through cycles 1-33: no restart ----------------
        op    = MD_MULTU;
        src_a = 32'd3;
        src_b = 32'd5;
        start = 1'b1;
        @(posedge CLK);
        #1;
        sb.push_back('{lohi: 64'd15, dbz: 1'b0, due: cyc + 33, id: 22});
        repeat (33) @(posedge CLK);
        #1 start = 1'b0;
        wait_done(22);

        // ---------------- back-to-back: start in the DONE cycle ----------------
        launch(MD_DIVU, 32'd1000, 32'd10, 64'd100, 1'b0, 23, 1'b1);
        repeat (33) @(posedge CLK);
        #1;
        check("b2b_in_done", {63'b0, done}, 64'd1);
        launch(MD_MULT, 32'd2, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF6, 1'b0, 24, 1'b1);
        wait_done(24);

        // ---------------- start + flush together in IDLE ----------------
        @(posedge CLK);
        #1;
        op    = MD_MULTU;
        src_a = 32'd1;
        src_b = 32'd1;
        start = 1'b1;
        flush = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge CLK);
        check("start_flush_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge CLK);
        check("start_flush_lohi", loHi_out, 64'hFFFF_FFFF_FFFF_FFF6);

        // ---------------- asynchronous reset mid-RUN (cycle 17) ----------------
        launch(MD_MULTU, 32'd9, 32'd9, 64'd0, 1'b0, 25, 1'b0);
        repeat (16) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("arst_busy", {63'b0, busy}, 64'd0);
        check("arst_done", {63'b0, done}, 64'd0);
        check("arst_lohi", loHi_out, 64'd0);
        check("arst_dbz", {63'b0, div_by_zero}, 64'd0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        launch(MD_MULT, 32'd2, 32'd3, 64'd6, 1'b0, 26, 1'b1);
        wait_done(26);

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_muldiv_sequencer
`default_nettype wire
